regs_mp: RTL and testbench
==========================

// Module: regs_mp
// PURPOSE
//  Parametrised multi-port integer register file for the next-generation pipelined core.
//  Provides NRD combinational read ports with write-to-read forwarding, and two prioritised write ports (WB/ALU and CSR/load).
//  Includes a per-register busy scoreboard for hazard detection, a debug read port, and a synchronous clear sweep after reset.
//  Sits in ID: reads feed operand muxes; write ports driven from WB; issue port driven from ID.
// PARAMETERS
//  XLEN     32  data width
//  NREGS    32  number of architectural registers
//  NRD      2   number of read ports
//  ZERO_REG 1   1: register 0 hardwired to zero (writes dropped, never busy)
//  AW       $clog2(NREGS)  address width (derived, not overridden)
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         synchronous, active-high reset
//  ready      out  1         1 = clear sweep done, file usable
//  raddr      in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  rdata      out  NRD*XLEN  read data (combinational, forwarded)
//  rbusy      out  NRD       scoreboard busy for each read address
//  we0/wa0/wd0 in  1/AW/XLEN write port 0 (low priority)
//  we1/wa1/wd1 in  1/AW/XLEN write port 1 (high priority)
//  iss_v      in   1         issue: mark iss_addr busy (pending producer)
//  iss_addr   in   AW        destination register of issued instruction
//  dbg_addr   in   AW        debug/display address
//  dbg_data   out  XLEN      debug read, raw array value, no forwarding
// BEHAVIOUR
//  - FSM {CLEAR, RUN}. A rising edge with rst=1 forces CLEAR, sets idx=0, and clears all busy bits.
//  - CLEAR: each cycle writes reg[idx]=0 and increments idx; at idx==NREGS-1 it writes zero and moves to RUN.
//    The sweep is exactly NREGS cycles after rst deasserts. rst=1 mid-sweep restarts at idx=0.
//  - ready = (state==RUN) && !rst. While not ready: rdata=0, rbusy=0, and writes and issues are ignored.
//    dbg_data still reads the array.
//  - Write: port p is effective when we_p && !(ZERO_REG && wa_p==0). Effective ports update the array on the edge.
//    If both ports target the same address, port 1's data is stored.
//  - Read port i, per cycle:
//    - addr==0 && ZERO_REG -> 0.
//    - Else, if effective port 1 hits the address -> wd1.
//    - Else, if effective port 0 hits -> wd0.
//    - Else -> array value.
//  - Scoreboard update on the edge, for register r:
//    - Effective write to r clears busy[r].
//    - iss_v to r sets busy[r]. Issue wins over a same-cycle write, because it names a new producer.
//    - iss_addr==0 with ZERO_REG is ignored.
//  - rbusy[i] = busy[raddr_i] && !(effective write to raddr_i this cycle). Writeback forwarding resolves the hazard in-cycle.
//  - Latency: reads 0 cycles (same-cycle forwarding); writes visible in the array 1 cycle later.
//  - Out-of-range addresses (when NREGS is not a power of 2): reads return 0; writes and issues are dropped.
//  - Reset values: array all 0 (after the sweep), busy all 0, state CLEAR, idx 0, ready 0.
// STRUCTURE
//  - Package regs_pkg holds: XLEN default, state typedef {CLEAR,RUN}, and function fwd_sel(addr,we0,wa0,we1,wa1) returning a 2-bit source select.
//  - One sub-module regs_fwd_mux, instantiated NRD times via generate, implements the per-port zero/forward/array selection plus the rbusy mask.
//  - Storage is a single array with two write ports plus the clear port. The clear port is muxed onto write port 0 during CLEAR.
// TESTING
//  1. Reset sweep: rst high 1 cycle, NREGS=32 -> ready=0 for exactly 32 cycles, then 1; every raddr reads 0x0.
//     Repeat with rst pulsed at sweep cycle 10 -> ready rises 32 cycles after the second pulse.
//  2. Forwarding: we0=1, wa0=5, wd0=0xDEADBEEF, raddr0=5 same cycle -> rdata0=0xDEADBEEF.
//     Next cycle, with no write, rdata0 still reads 0xDEADBEEF from the array.
//  3. Write collision: we0=1, wa0=7, wd0=0x11 and we1=1, wa1=7, wd1=0x22 -> rdata=0x22 in-cycle; dbg_addr=7 reads 0x22 next cycle.
//  4. Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF; iss_v=1, iss_addr=0 -> rdata for addr 0 = 0x0, rbusy=0, dbg_data(0)=0x0.
//  5. Scoreboard: iss_v to x9 -> next cycle rbusy=1.
//     Writeback x9=0x1234 with raddr1=9 -> rbusy1=0, rdata1=0x1234.
//     iss_v to x9 and write x9 in the same cycle -> busy stays 1.
//  6. Not ready: during CLEAR, we0 to x3 and iss_v to x3 -> after the sweep, x3 reads 0x0 and rbusy=0.

Source files
------------

// File: rtl/regs_pkg.sv
// regs_pkg: shared types, defaults and forwarding-select helper for the register file
package regs_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ADDR_W = 16;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [1:0] FWD_ARR = 2'd0;
  localparam logic [1:0] FWD_WD0 = 2'd1;
  localparam logic [1:0] FWD_WD1 = 2'd2;
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic we0,
    input logic [ADDR_W-1:0] wa0,
    input logic we1,
    input logic [ADDR_W-1:0] wa1
  );
    return (we1 && wa1 == addr) ? FWD_WD1 : (we0 && wa0 == addr) ? FWD_WD0 : FWD_ARR;
  endfunction
endpackage

// File: rtl/regs_fwd_mux.sv
// regs_fwd_mux: per-read-port zero/forward/array select plus busy mask
module regs_fwd_mux import regs_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            ready,
  input  logic            valid,
  input  logic [AW-1:0]   addr,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic [XLEN-1:0] arr,
  input  logic            busy,
  output logic [XLEN-1:0] rdata,
  output logic            rbusy
);
  logic [1:0] w_sel;
  logic w_zero;
  assign w_sel = fwd_sel(ADDR_W'(addr), we0, ADDR_W'(wa0), we1, ADDR_W'(wa1));
  assign w_zero = !ready || !valid || (ZERO_REG && addr == '0);
  assign rdata = w_zero ? '0 : (w_sel == FWD_WD1) ? wd1 : (w_sel == FWD_WD0) ? wd0 : arr;
  // a same-cycle writeback to this address satisfies the pending producer
  assign rbusy = !w_zero && busy && w_sel == FWD_ARR;
endmodule

// File: rtl/regs_mp.sv
// regs_mp: multi-port register file with write forwarding, busy scoreboard
// and a post-reset clear sweep muxed onto write port 0
module regs_mp import regs_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [XLEN-1:0]   wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);
  state_t r_state;
  logic [AW-1:0] r_idx;
  logic [NREGS-1:0] r_busy;
  logic [XLEN-1:0] r_mem [NREGS];
  logic w_clr, w_we0, w_we1, w_iss, w_pe0;
  logic [AW-1:0] w_pa0;
  logic [XLEN-1:0] w_pd0;
  function automatic logic in_rng(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(NREGS);
  endfunction
  function automatic logic wr_ok(input logic [AW-1:0] a);
    return in_rng(a) && !(ZERO_REG && a == '0);
  endfunction
  assign ready = r_state == RUN && !rst;
  assign w_clr = r_state == CLEAR && !rst;
  assign w_we0 = ready && we0 && wr_ok(wa0);
  assign w_we1 = ready && we1 && wr_ok(wa1);
  assign w_iss = ready && iss_v && wr_ok(iss_addr);
  assign w_pe0 = w_clr || w_we0;
  assign w_pa0 = w_clr ? r_idx : wa0;
  assign w_pd0 = w_clr ? '0 : wd0;
  assign dbg_data = in_rng(dbg_addr) ? r_mem[dbg_addr] : '0;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= CLEAR;
      r_idx <= '0;
      r_busy <= '0;
    end else if (r_state == CLEAR) begin
      r_idx <= r_idx + 1'b1;
      if (r_idx == AW'(NREGS - 1)) r_state <= RUN;
    end else
      for (int r = 0; r < NREGS; r++)
        if (w_iss && iss_addr == AW'(r)) r_busy[r] <= 1'b1;
        else if ((w_we0 && wa0 == AW'(r)) || (w_we1 && wa1 == AW'(r))) r_busy[r] <= 1'b0;
  // port 1 is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (w_pe0) r_mem[w_pa0] <= w_pd0;
    if (w_we1) r_mem[wa1] <= wd1;
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = raddr[i*AW +: AW];
    regs_fwd_mux #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG)) u_mux (
      .ready(ready),
      .valid(in_rng(w_a)),
      .addr(w_a),
      .we0(w_we0),
      .wa0(wa0),
      .wd0(wd0),
      .we1(w_we1),
      .wa1(wa1),
      .wd1(wd1),
      .arr(in_rng(w_a) ? r_mem[w_a] : '0),
      .busy(in_rng(w_a) && r_busy[w_a]),
      .rdata(rdata[i*XLEN +: XLEN]),
      .rbusy(rbusy[i])
    );
  end
endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp: directed and randomized checks of regs_mp against a behavioural model
module tb_regs_mp;
  logic clk = 1'b0;
  logic rst, ready, we0, we1, iss_v;
  logic [9:0] raddr;
  logic [63:0] rdata;
  logic [1:0] rbusy;
  logic [4:0] wa0, wa1, iss_addr, dbg_addr;
  logic [31:0] wd0, wd1, dbg_data;
  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic [31:0] m_mem [32];
  bit m_busy [32];
  bit m_init = 0, m_rdy = 0, m_swept = 0;
  int m_cnt = 0;

  regs_mp dut (
    .clk(clk), .rst(rst), .ready(ready), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_v(iss_v), .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // model: sweep zeroes one register per cycle, then writes/issues follow the rules
  always @(posedge clk) begin
    if (rst) begin
      m_init = 1;
      m_rdy = 0;
      m_cnt = 0;
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
    end else if (m_init && !m_rdy) begin
      m_mem[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == 32) begin
        m_rdy = 1;
        m_swept = 1;
      end
    end else if (m_rdy) begin
      if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_busy[wa0] = 0; end
      if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 0; end
      if (iss_v && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!(m_rdy && !rst) || a == 0) return 0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a);
    return m_rdy && !rst && a != 0 && m_busy[a] && !(we1 && wa1 == a) && !(we0 && wa0 == a);
  endfunction

  always @(negedge clk) if (m_init) begin
    chk("ready", 32'(ready), 32'(m_rdy && !rst));
    for (int i = 0; i < 2; i++) begin
      chk("rdata", rdata[i*32 +: 32], exp_rd(raddr[i*5 +: 5]));
      chk("rbusy", 32'(rbusy[i]), 32'(exp_bz(raddr[i*5 +: 5])));
    end
    if (m_swept) chk("dbg_data", dbg_data, m_mem[dbg_addr]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; wa0 = 0; wd0 = 0;
    we1 = 0; wa1 = 0; wd1 = 0;
    iss_v = 0; iss_addr = 0;
  endtask

  task automatic do_rst();
    step();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic count_sweep(output int cnt);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (ready) break;
      cnt++;
      step();
      idle();
    end
  endtask

  function automatic logic [4:0] ra();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    raddr = 0;
    dbg_addr = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    count_sweep(n);
    chk("sweep_len", 32'(n), 32);
    for (int a = 0; a < 32; a++) begin
      step();
      raddr = {5'(31 - a), 5'(a)};
      dbg_addr = 5'(a);
      @(negedge clk);
      chk("swept_rd0", rdata[31:0], 0);
      chk("swept_rd1", rdata[63:32], 0);
      chk("swept_dbg", dbg_data, 0);
    end
    do_rst();
    repeat (10) step();
    do_rst();
    we0 = 1; wa0 = 3; wd0 = 32'h55;
    iss_v = 1; iss_addr = 3;
    count_sweep(n);
    chk("resweep_len", 32'(n), 32);
    step();
    raddr = {5'd0, 5'd3};
    dbg_addr = 3;
    @(negedge clk);
    chk("clr_x3_rd", rdata[31:0], 0);
    chk("clr_x3_busy", 32'(rbusy[0]), 0);
    chk("clr_x3_dbg", dbg_data, 0);
    step();
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    @(negedge clk);
    chk("fwd_wd0", rdata[31:0], 32'hDEADBEEF);
    step();
    idle();
    @(negedge clk);
    chk("arr_x5", rdata[31:0], 32'hDEADBEEF);
    step();
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; raddr = {5'd7, 5'd5};
    @(negedge clk);
    chk("collide_fwd", rdata[63:32], 32'h22);
    step();
    idle();
    dbg_addr = 7;
    @(negedge clk);
    chk("collide_dbg", dbg_data, 32'h22);
    step();
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; iss_v = 1; iss_addr = 0; raddr = {5'd7, 5'd0};
    @(negedge clk);
    chk("zero_rd", rdata[31:0], 0);
    chk("zero_busy", 32'(rbusy[0]), 0);
    step();
    idle();
    dbg_addr = 0;
    @(negedge clk);
    chk("zero_dbg", dbg_data, 0);
    chk("zero_busy2", 32'(rbusy[0]), 0);
    step();
    iss_v = 1; iss_addr = 9;
    step();
    idle();
    raddr = {5'd9, 5'd0};
    @(negedge clk);
    chk("iss_busy", 32'(rbusy[1]), 1);
    step();
    we0 = 1; wa0 = 9; wd0 = 32'h1234;
    @(negedge clk);
    chk("wb_busy", 32'(rbusy[1]), 0);
    chk("wb_rd", rdata[63:32], 32'h1234);
    step();
    idle();
    iss_v = 1; iss_addr = 9; we1 = 1; wa1 = 9; wd1 = 32'h5678;
    step();
    idle();
    @(negedge clk);
    chk("iss_wins", 32'(rbusy[1]), 1);
    chk("iss_wins_rd", rdata[63:32], 32'h5678);
    repeat (1500) begin
      step();
      rst = ($urandom_range(0, 399) == 0);
      we0 = 1'($urandom_range(0, 1)); wa0 = ra(); wd0 = $urandom();
      we1 = 1'($urandom_range(0, 1)); wa1 = ra(); wd1 = $urandom();
      iss_v = ($urandom_range(0, 2) == 0); iss_addr = ra();
      raddr = {ra(), ra()};
      dbg_addr = ra();
    end
    step();
    idle();
    rst = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
